// File: rtl/fmul_iter_if.sv
// Operand/result handshake bundle for the iterative multiplier.
interface fmul_iter_if #(
    parameter int unsigned W = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [3:0]   flags;

    modport master (
        output in_valid, x, y, out_ready,
        input  in_ready, out_valid, result, flags
    );

    modport slave (
        input  in_valid, x, y, out_ready,
        output in_ready, out_valid, result, flags
    );
endinterface

// File: rtl/fmul_iter.sv
// Iterative IEEE-style multiplier: shift-add significand product, one multiplier
// bit per cycle, RNE rounding, DAZ/FTZ, flags {invalid, overflow, underflow, inexact}.
module fmul_iter #(
    parameter int unsigned EW = 5,
    parameter int unsigned FW = 10
) (
    input logic        clk,
    input logic        reset,
    fmul_iter_if.slave bus
);
    localparam int unsigned W  = 1 + EW + FW;
    localparam int unsigned CW = $clog2(FW + 2);
    localparam int unsigned PW = 2 * (FW + 1);

    localparam logic signed [EW+1:0] Bias    = (EW+2)'((1 << (EW - 1)) - 1);
    localparam logic signed [EW+1:0] ExpMax  = (EW+2)'((1 << EW) - 1);
    localparam logic [CW-1:0]        CntLast = CW'(FW);
    localparam logic [W-1:0]         QNaN    = {1'b0, {EW{1'b1}}, 1'b1, {(FW-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StMul, StNorm, StDone} state_e;

    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q;
    logic [PW-1:0]          acc_q;
    logic [FW:0]            mcand_q, mplier_q;
    logic signed [EW+1:0]   exp_q;
    logic                   sign_q;
    logic [W-1:0]           result_q;
    logic [3:0]             flags_q;

    // Operand fields and classes
    logic          x_s, y_s;
    logic [EW-1:0] x_e, y_e;
    logic [FW-1:0] x_f, y_f;
    logic          x_zero, y_zero, x_inf, y_inf, x_nan, y_nan;
    logic          accept;
    logic signed [EW+1:0] exp_sum;

    assign {x_s, x_e, x_f} = bus.x;
    assign {y_s, y_e, y_f} = bus.y;
    // Exponent field zero covers subnormals too: they are treated as zero.
    assign x_zero  = (x_e == '0);
    assign y_zero  = (y_e == '0);
    assign x_inf   = (&x_e) & ~(|x_f);
    assign y_inf   = (&y_e) & ~(|y_f);
    assign x_nan   = (&x_e) & (|x_f);
    assign y_nan   = (&y_e) & (|y_f);
    assign accept  = bus.in_valid & (state_q == StIdle);
    assign exp_sum = $signed({2'b00, x_e}) + $signed({2'b00, y_e}) - Bias;

    // Special-operand shortcut: decides whether the datapath can be skipped
    logic         spec_hit;
    logic [W-1:0] spec_res;
    logic [3:0]   spec_flags;
    always_comb begin
        spec_hit   = 1'b1;
        spec_res   = '0;
        spec_flags = '0;
        if (x_nan | y_nan) begin
            spec_res   = QNaN;
            spec_flags = {(x_nan & ~x_f[FW-1]) | (y_nan & ~y_f[FW-1]), 3'b000};
        end else if ((x_inf & y_zero) | (x_zero & y_inf)) begin
            spec_res   = QNaN;
            spec_flags = 4'b1000;
        end else if (x_inf | y_inf) begin
            spec_res = {x_s ^ y_s, {EW{1'b1}}, {FW{1'b0}}};
        end else if (x_zero | y_zero) begin
            spec_res = {x_s ^ y_s, {(W-1){1'b0}}};
        end else begin
            spec_hit = 1'b0;
        end
    end

    // One shift-add step: add multiplicand into the upper half, shift right
    logic [FW+1:0] add_sum;
    logic [PW-1:0] acc_step;
    always_comb begin
        add_sum  = {1'b0, acc_q[PW-1:FW+1]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
        acc_step = {add_sum, acc_q[FW:1]};
    end

    // Normalise, round to nearest even, range-check the finished product
    logic                 prod_hi, guard, sticky, rnd_up;
    logic [PW-1:0]        norm;
    logic [FW-1:0]        frac;
    logic [FW:0]          frac_r;
    logic signed [EW+1:0] exp_n;
    logic [W-1:0]         norm_res;
    logic [3:0]           norm_flags;
    always_comb begin
        prod_hi = acc_q[PW-1];
        norm    = prod_hi ? acc_q : {acc_q[PW-2:0], 1'b0};
        frac    = norm[PW-2:FW+1];
        guard   = norm[FW];
        sticky  = |norm[FW-1:0];
        rnd_up  = guard & (sticky | frac[0]);
        frac_r  = {1'b0, frac} + {{FW{1'b0}}, rnd_up};
        // A rounding carry leaves frac_r[FW-1:0] all zero, so only the exponent moves.
        exp_n   = exp_q + (EW+2)'(prod_hi) + (EW+2)'(frac_r[FW]);
        norm_res   = {sign_q, exp_n[EW-1:0], frac_r[FW-1:0]};
        norm_flags = {3'b000, guard | sticky};
        if (exp_n >= ExpMax) begin
            norm_res   = {sign_q, {EW{1'b1}}, {FW{1'b0}}};
            norm_flags = 4'b0101;
        end else if (exp_n[EW+1] || exp_n == '0) begin
            norm_res   = {sign_q, {(W-1){1'b0}}};
            norm_flags = 4'b0011;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = spec_hit ? StDone : StMul;
            StMul:   if (cnt_q == CntLast) state_d = StNorm;
            StNorm:  state_d = StDone;
            StDone:  if (bus.out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // Datapath and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            exp_q    <= '0;
            sign_q   <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        sign_q   <= x_s ^ y_s;
                        exp_q    <= exp_sum;
                        mcand_q  <= {1'b1, x_f};
                        mplier_q <= {1'b1, y_f};
                        cnt_q    <= '0;
                        acc_q    <= '0;
                        flags_q  <= spec_hit ? spec_flags : 4'b0000;
                        if (spec_hit) result_q <= spec_res;
                    end
                end
                StMul: begin
                    acc_q    <= acc_step;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;
                end
                StNorm: begin
                    result_q <= norm_res;
                    flags_q  <= norm_flags;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.result    = result_q;
    assign bus.flags     = flags_q;
endmodule

// File: tb/tb_fmul_iter.sv
// Directed bench for fmul_iter: binary16 instance plus a binary32 instance.
module tb_fmul_iter;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    fmul_iter_if #(.W(16)) bus16();
    fmul_iter_if #(.W(32)) bus32();

    fmul_iter #(.EW(5), .FW(10)) dut16 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus16)
    );

    fmul_iter #(.EW(8), .FW(23)) dut32 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus32)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One binary16 operation. lat = edges after the accept edge until out_valid.
    // hold = cycles out_ready stays low in DONE while in_valid is pulsed.
    task automatic run16(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] er, input logic [3:0] ef, input int lat,
                         input int hold);
        int n;
        check({tag, " in_ready"}, 32'(bus16.in_ready), 32'd1);
        bus16.out_ready = (hold == 0);
        bus16.x = a;
        bus16.y = b;
        bus16.in_valid = 1'b1;
        tick();
        bus16.in_valid = 1'b0;
        bus16.x = 16'h0000;
        bus16.y = 16'h0000;
        check({tag, " busy"}, 32'(bus16.in_ready), 32'd0);
        n = 0;
        while (!bus16.out_valid && n < 60) begin
            tick();
            n++;
        end
        check({tag, " latency"}, 32'(n), 32'(lat));
        check({tag, " result"}, 32'(bus16.result), 32'(er));
        check({tag, " flags"}, 32'(bus16.flags), 32'(ef));
        for (int i = 0; i < hold; i++) begin
            bus16.in_valid = 1'b1;
            bus16.x = 16'h3C00;
            bus16.y = 16'h3C00;
            tick();
            check({tag, " hold result"}, 32'(bus16.result), 32'(er));
            check({tag, " hold flags"}, 32'(bus16.flags), 32'(ef));
            check({tag, " hold valid"}, 32'(bus16.out_valid), 32'd1);
            check({tag, " hold ready"}, 32'(bus16.in_ready), 32'd0);
        end
        bus16.in_valid = 1'b0;
        bus16.out_ready = 1'b1;
        tick();
        check({tag, " back idle"}, 32'(bus16.out_valid), 32'd0);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        bus16.in_valid = 1'b0;
        bus16.x = '0;
        bus16.y = '0;
        bus16.out_ready = 1'b1;
        bus32.in_valid = 1'b0;
        bus32.x = '0;
        bus32.y = '0;
        bus32.out_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("reset in_ready", 32'(bus16.in_ready), 32'd1);
        check("reset out_valid", 32'(bus16.out_valid), 32'd0);
        check("reset result", 32'(bus16.result), 32'd0);
        check("reset flags", 32'(bus16.flags), 32'd0);

        // Normal operands: FW+2 = 12 edges after accept
        run16("1.5*2", 16'h3E00, 16'h4000, 16'h4200, 4'b0000, 12, 0);
        run16("-2*3", 16'hC000, 16'h4200, 16'hC600, 4'b0000, 12, 0);
        // Rounding
        run16("rnd 3C01^2", 16'h3C01, 16'h3C01, 16'h3C02, 4'b0001, 12, 0);
        run16("1*3555", 16'h3C00, 16'h3555, 16'h3555, 4'b0000, 12, 0);
        // Specials go straight to DONE: valid in the cycle after the accept cycle
        run16("inf*0", 16'h7C00, 16'h0000, 16'h7E00, 4'b1000, 0, 0);
        run16("snan", 16'h7D00, 16'h3C00, 16'h7E00, 4'b1000, 0, 0);
        run16("-inf*2", 16'hFC00, 16'h4000, 16'hFC00, 4'b0000, 0, 0);
        // Range
        run16("ovf", 16'h7BFF, 16'h7BFF, 16'h7C00, 4'b0101, 12, 0);
        run16("unf", 16'h0400, 16'h0400, 16'h0000, 4'b0011, 12, 0);
        run16("daz", 16'h8001, 16'h3C00, 16'h8000, 4'b0000, 0, 0);
        // Output stall then back-to-back accept
        run16("stall", 16'h3E00, 16'h4000, 16'h4200, 4'b0000, 12, 5);
        run16("b2b", 16'hC000, 16'h4200, 16'hC600, 4'b0000, 12, 0);

        // Reset in the middle of MUL
        bus16.x = 16'h3E00;
        bus16.y = 16'h4000;
        bus16.in_valid = 1'b1;
        tick();
        bus16.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midreset in_ready", 32'(bus16.in_ready), 32'd1);
        check("midreset out_valid", 32'(bus16.out_valid), 32'd0);
        check("midreset result", 32'(bus16.result), 32'd0);
        check("midreset flags", 32'(bus16.flags), 32'd0);
        run16("after reset", 16'h3E00, 16'h4000, 16'h4200, 4'b0000, 12, 0);

        // binary32: 1.5*2.0 = 3.0, FW+2 = 25 edges
        check("f32 in_ready", 32'(bus32.in_ready), 32'd1);
        bus32.x = 32'h3FC00000;
        bus32.y = 32'h40000000;
        bus32.in_valid = 1'b1;
        tick();
        bus32.in_valid = 1'b0;
        n = 0;
        while (!bus32.out_valid && n < 80) begin
            tick();
            n++;
        end
        check("f32 latency", 32'(n), 32'd25);
        check("f32 result", bus32.result, 32'h40400000);
        check("f32 flags", 32'(bus32.flags), 32'd0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
